tpg_pattern_gen: RTL and testbench

Parametrised second-generation video test pattern generator. It sits in the video path between the timing generator and the frame-buffer/DDR write stage, and substitutes test content for camera data. Channel width, active resolution, grid size, bar width and auto-cycle rate are all configurable. It adds host-selectable or auto-cycling modes (switched only at frame boundaries), a moving box, a border pattern, and sync/DE outputs aligned exactly with the pixel data.

---
 rtl/tpg_pattern_gen_if.sv | 23 ++
 rtl/tpg_pattern_gen.sv | 172 +++++++++++++++++
 tb/tb_tpg_pattern_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tpg_pattern_gen_if.sv
// Video timing/data bundle between the timing generator, the pattern generator
// and the frame-buffer write stage.
interface tpg_pattern_gen_if #(
   parameter int DATA_W = 8
);
   logic                tpg_vs_i;
   logic                tpg_hs_i;
   logic                tpg_de_i;
   logic                tpg_vs_o;
   logic                tpg_hs_o;
   logic                tpg_de_o;
   logic [3*DATA_W-1:0] tpg_data_o;

   modport master (
      output tpg_vs_i, tpg_hs_i, tpg_de_i,
      input  tpg_vs_o, tpg_hs_o, tpg_de_o, tpg_data_o
   );

   modport slave (
      input  tpg_vs_i, tpg_hs_i, tpg_de_i,
      output tpg_vs_o, tpg_hs_o, tpg_de_o, tpg_data_o
   );
endinterface

// File: rtl/tpg_pattern_gen.sv
// Video test pattern generator: replaces camera data with one of eight
// patterns, switching mode/colour/box position only at frame start.
module tpg_pattern_gen #(
   parameter int DATA_W          = 8,
   parameter int CNT_W           = 12,
   parameter int H_ACT           = 1920,
   parameter int V_ACT           = 1080,
   parameter int GRID_LOG2       = 4,
   parameter int BAR_W           = 240,
   parameter int BOX_SIZE        = 64,
   parameter int FRAMES_PER_MODE = 128
) (
   input  logic                  tpg_clk_i,
   input  logic                  tpg_rst_i,
   tpg_pattern_gen_if.slave      vid,
   input  logic                  mode_auto_i,
   input  logic [2:0]            mode_sel_i,
   input  logic [3*DATA_W-1:0]   color_i,
   output logic [2:0]            mode_o
);
   localparam int PIX_W = 3*DATA_W;
   localparam int FC_W  = $clog2(FRAMES_PER_MODE+1);
   localparam int BP_W  = $clog2(BAR_W+1);
   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACT-1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACT-1);
   localparam logic [CNT_W-1:0] BOX_X_MAX = CNT_W'(H_ACT-BOX_SIZE);
   localparam logic [CNT_W-1:0] BOX_Y0    = CNT_W'(V_ACT/2-BOX_SIZE/2);
   localparam logic [CNT_W:0]   BOX_SZ    = (CNT_W+1)'(BOX_SIZE);
   localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAMES_PER_MODE-1);
   localparam logic [BP_W-1:0]  BAR_LAST  = BP_W'(BAR_W-1);

   function automatic logic [2:0] sat_inc(input logic [2:0] b);
      return (b == 3'd7) ? 3'd7 : b + 3'd1;
   endfunction

   function automatic logic [PIX_W-1:0] pixel_f(
      input logic [2:0]       mode,
      input logic [CNT_W-1:0] h,
      input logic [CNT_W-1:0] v,
      input logic [2:0]       bar,
      input logic [PIX_W-1:0] color,
      input logic [CNT_W-1:0] box
   );
      logic [CNT_W-1:0] diag;
      logic             in_x;
      logic             in_y;
      diag = h + v;
      in_x = (h >= box) && ({1'b0, h} < ({1'b0, box} + BOX_SZ));
      in_y = (v >= BOX_Y0) && ({1'b0, v} < ({1'b0, BOX_Y0} + BOX_SZ));
      case (mode)
         3'd0:    pixel_f = {3{h[DATA_W-1:0]}};
         3'd1:    pixel_f = {3{v[DATA_W-1:0]}};
         3'd2:    pixel_f = color;
         3'd3:    pixel_f = {PIX_W{h[GRID_LOG2] == v[GRID_LOG2]}};
         // Bar order white..black falls out of the inverted index bits.
         3'd4:    pixel_f = {{DATA_W{~bar[1]}}, {DATA_W{~bar[2]}}, {DATA_W{~bar[0]}}};
         3'd5:    pixel_f = {PIX_W{in_x && in_y}};
         3'd6:    pixel_f = {PIX_W{(h == '0) || (h == H_LAST) || (v == '0) || (v == V_LAST)}};
         default: pixel_f = {3{diag[DATA_W-1:0]}};
      endcase
   endfunction

   logic             vs_q, de_q;
   logic [CNT_W-1:0] h_cnt, v_cnt, box_x;
   logic [BP_W-1:0]  bar_pix;
   logic [2:0]       bar_idx, mode_r;
   logic [FC_W-1:0]  frame_cnt;
   logic [PIX_W-1:0] color_r;

   logic             fs;
   logic [2:0]       mode_nxt;
   logic [FC_W-1:0]  fc_nxt;
   logic [PIX_W-1:0] color_nxt;
   logic [CNT_W-1:0] box_nxt, v_cur;

   logic             vs_p1, hs_p1, vld_p1;
   logic [CNT_W-1:0] h_p1, v_p1, box_p1;
   logic [2:0]       bar_p1, mode_p1;
   logic [PIX_W-1:0] color_p1;
   logic             vs_p2, hs_p2, vld_p2;
   logic [PIX_W-1:0] data_p2;

   assign fs    = vid.tpg_vs_i & ~vs_q;
   assign v_cur = vid.tpg_vs_i ? '0 : v_cnt;

   // Frame-start updates are also fed straight into stage 1 so a pixel in the fs cycle uses them.
   always_comb begin
      mode_nxt  = mode_r;
      fc_nxt    = frame_cnt;
      color_nxt = color_r;
      box_nxt   = box_x;
      if (fs) begin
         if (mode_auto_i) begin
            if (frame_cnt == FC_LAST) begin
               fc_nxt   = '0;
               mode_nxt = mode_r + 3'd1;
            end else begin
               fc_nxt   = frame_cnt + FC_W'(1);
            end
         end else begin
            mode_nxt = mode_sel_i;
            fc_nxt   = '0;
         end
         color_nxt = color_i;
         box_nxt   = (box_x >= BOX_X_MAX) ? '0 : box_x + CNT_W'(1);
      end
   end

   // Stage 1: counters, frame state and per-pixel coordinates/mode.
   always_ff @(posedge tpg_clk_i) begin
      if (tpg_rst_i) begin
         vs_q <= 1'b0;  de_q <= 1'b0;
         h_cnt <= '0;  v_cnt <= '0;  box_x <= '0;
         bar_pix <= '0;  bar_idx <= '0;
         mode_r <= '0;  frame_cnt <= '0;  color_r <= '0;
         vs_p1 <= 1'b0;  hs_p1 <= 1'b0;  vld_p1 <= 1'b0;
         h_p1 <= '0;  v_p1 <= '0;  box_p1 <= '0;
         bar_p1 <= '0;  mode_p1 <= '0;  color_p1 <= '0;
      end else begin
         vs_q      <= vid.tpg_vs_i;
         de_q      <= vid.tpg_de_i;
         mode_r    <= mode_nxt;
         frame_cnt <= fc_nxt;
         color_r   <= color_nxt;
         box_x     <= box_nxt;
         h_cnt     <= vid.tpg_de_i ? h_cnt + CNT_W'(1) : '0;
         if (vid.tpg_vs_i)
            v_cnt <= '0;
         else if (de_q && !vid.tpg_de_i)
            v_cnt <= v_cnt + CNT_W'(1);
         if (!vid.tpg_de_i) begin
            bar_pix <= '0;
            bar_idx <= '0;
         end else if (bar_pix == BAR_LAST) begin
            bar_pix <= '0;
            bar_idx <= sat_inc(bar_idx);
         end else begin
            bar_pix <= bar_pix + BP_W'(1);
         end
         vs_p1    <= vid.tpg_vs_i;
         hs_p1    <= vid.tpg_hs_i;
         vld_p1   <= vid.tpg_de_i;
         h_p1     <= h_cnt;
         v_p1     <= v_cur;
         bar_p1   <= bar_idx;
         mode_p1  <= mode_nxt;
         color_p1 <= color_nxt;
         box_p1   <= box_nxt;
      end
   end

   // Stage 2: pixel generation, blanked outside DE.
   always_ff @(posedge tpg_clk_i) begin
      if (tpg_rst_i) begin
         vs_p2   <= 1'b0;
         hs_p2   <= 1'b0;
         vld_p2  <= 1'b0;
         data_p2 <= '0;
      end else begin
         vs_p2   <= vs_p1;
         hs_p2   <= hs_p1;
         vld_p2  <= vld_p1;
         data_p2 <= vld_p1 ? pixel_f(mode_p1, h_p1, v_p1, bar_p1, color_p1, box_p1) : '0;
      end
   end

   assign vid.tpg_vs_o   = vs_p2;
   assign vid.tpg_hs_o   = hs_p2;
   assign vid.tpg_de_o   = vld_p2;
   assign vid.tpg_data_o = data_p2;
   assign mode_o         = mode_r;
endmodule

// File: tb/tb_tpg_pattern_gen.sv
// Directed bench for tpg_pattern_gen at a 64x16 test geometry.
module tb_tpg_pattern_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode_auto = 1'b0;
   logic [2:0]  mode_sel = 3'd0;
   logic [23:0] color = 24'h0;
   logic [2:0]  mode_o;

   int    checks = 0;
   int    failures = 0;
   string tag = "reset";
   logic        pend = 1'b0;
   logic        p_vs, p_hs, p_de;
   logic [23:0] p_data;
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   tpg_pattern_gen_if #(.DATA_W(8)) vid ();

   tpg_pattern_gen #(
      .DATA_W(8), .CNT_W(12), .H_ACT(64), .V_ACT(16), .GRID_LOG2(2),
      .BAR_W(8), .BOX_SIZE(8), .FRAMES_PER_MODE(2)
   ) dut (
      .tpg_clk_i   (clk),
      .tpg_rst_i   (rst),
      .vid         (vid),
      .mode_auto_i (mode_auto),
      .mode_sel_i  (mode_sel),
      .color_i     (color),
      .mode_o      (mode_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [23:0] exp_pix(input int mode, input int h, input int v,
                                           input int box, input logic [23:0] col);
      logic [7:0] b;
      case (mode)
         0: begin b = 8'(h); return {b, b, b}; end
         1: begin b = 8'(v); return {b, b, b}; end
         2: return col;
         3: return (((h / 4) % 2) == ((v / 4) % 2)) ? 24'hFFFFFF : 24'h0;
         4: return bars[(h < 64) ? h / 8 : 7];
         5: return (h >= box && h < box + 8 && v >= 4 && v < 12) ? 24'hFFFFFF : 24'h0;
         6: return (h == 0 || h == 63 || v == 0 || v == 15) ? 24'hFFFFFF : 24'h0;
         default: begin b = 8'(h + v); return {b, b, b}; end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Outputs seen after this edge belong to the inputs of the previous call.
   task automatic drive(input logic vs, input logic hs, input logic de, input logic [23:0] exp);
      vid.tpg_vs_i = vs;
      vid.tpg_hs_i = hs;
      vid.tpg_de_i = de;
      tick();
      if (pend)
         chk({tag, " out"}, {5'd0, vid.tpg_vs_o, vid.tpg_hs_o, vid.tpg_de_o, vid.tpg_data_o},
             {5'd0, p_vs, p_hs, p_de, p_data});
      p_vs = vs;  p_hs = hs;  p_de = de;  p_data = exp;
      pend = 1'b1;
   endtask

   task automatic line(input int mode, input int v, input int n_de, input int box,
                       input logic [23:0] col);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      for (int h = 0; h < n_de; h++)
         drive(1'b0, 1'b0, 1'b1, exp_pix(mode, h, v, box, col));
      for (int i = 0; i < 4; i++)
         drive(1'b0, (i < 2), 1'b0, 24'h0);
   endtask

   task automatic frame(input logic [2:0] exp_mode);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      chk({tag, " mode"}, {29'd0, mode_o}, {29'd0, exp_mode});
      drive(1'b1, 1'b0, 1'b0, 24'h0);
   endtask

   task automatic do_reset();
      vid.tpg_vs_i = 1'b0;  vid.tpg_hs_i = 1'b0;  vid.tpg_de_i = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      pend = 1'b0;
   endtask

   initial begin
      vid.tpg_vs_i = 1'b1;  vid.tpg_hs_i = 1'b1;  vid.tpg_de_i = 1'b1;
      color = 24'h5A5A5A;
      rst = 1'b1;
      tick(); tick(); tick();
      chk("reset out", {5'd0, vid.tpg_vs_o, vid.tpg_hs_o, vid.tpg_de_o, vid.tpg_data_o}, 32'd0);
      chk("reset mode", {29'd0, mode_o}, 32'd0);
      vid.tpg_vs_i = 1'b0;  vid.tpg_hs_i = 1'b0;  vid.tpg_de_i = 1'b0;
      rst = 1'b0;

      tag = "hramp";
      mode_sel = 3'd0;
      frame(3'd0);
      line(0, 0, 64, 0, 24'h0);
      line(0, 1, 64, 0, 24'h0);

      tag = "bars";
      mode_sel = 3'd4;
      frame(3'd4);
      line(4, 0, 72, 0, 24'h0);

      tag = "checker";
      mode_sel = 3'd3;
      frame(3'd3);
      for (int v = 0; v < 5; v++) line(3, v, 64, 0, 24'h0);

      tag = "solid";
      color = 24'h123456;
      mode_sel = 3'd2;
      frame(3'd2);
      line(2, 0, 64, 0, 24'h123456);
      color = 24'hABCDEF;
      mode_sel = 3'd7;
      line(2, 1, 64, 0, 24'h123456);
      chk("solid hold mode", {29'd0, mode_o}, 32'd2);
      mode_sel = 3'd2;
      frame(3'd2);
      line(2, 0, 64, 0, 24'hABCDEF);
      line(2, 1, 64, 0, 24'hABCDEF);
      line(2, 2, 64, 0, 24'hABCDEF);

      tag = "fs_de";
      mode_sel = 3'd1;
      drive(1'b1, 1'b0, 1'b1, 24'h000000);
      chk("fs_de mode", {29'd0, mode_o}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 24'h0);
      line(1, 0, 64, 0, 24'h0);
      line(1, 1, 64, 0, 24'h0);

      tag = "box";
      do_reset();
      mode_sel = 3'd5;
      for (int k = 1; k <= 3; k++) begin
         frame(3'd5);
         for (int v = 0; v < 16; v++) line(5, v, 64, k, 24'h0);
      end

      tag = "border";
      mode_sel = 3'd6;
      frame(3'd6);
      line(6, 0, 64, 0, 24'h0);
      line(6, 1, 72, 0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b1, exp_pix(6, 0, 2, 0, 24'h0));
      drive(1'b0, 1'b0, 1'b1, exp_pix(6, 1, 2, 0, 24'h0));
      rst = 1'b1;
      tick();
      chk("border rst out", {5'd0, vid.tpg_vs_o, vid.tpg_hs_o, vid.tpg_de_o, vid.tpg_data_o}, 32'd0);
      chk("border rst mode", {29'd0, mode_o}, 32'd0);
      rst = 1'b0;
      pend = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
      chk("border post mode", {29'd0, mode_o}, 32'd0);

      tag = "auto";
      mode_auto = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, 1'b0, 1'b0, 24'h0);
         chk($sformatf("auto fs%0d mode", k), {29'd0, mode_o}, 32'((k / 2) % 8));
         mode_sel = 3'(k);
         drive(1'b1, 1'b0, 1'b0, 24'h0);
         for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
         chk($sformatf("auto hold%0d mode", k), {29'd0, mode_o}, 32'((k / 2) % 8));
      end

      drive(1'b0, 1'b0, 1'b0, 24'h0);
      drive(1'b0, 1'b0, 1'b0, 24'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
